// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter: op-code values and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU; undefined op codes yield a zero result with err set.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic [OPW-1:0]   op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (op_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_NOR: result_o = ~(a_i | b_i);
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters; operands latched, result
// registered and returned over a valid/ready response port (IDLE -> EXEC -> RESP).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant, accept;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;

  // Contention flips away from the last served requester; a lone requester always wins.
  assign grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  alu_core #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_result),
    .err_o    (alu_err)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = grant ? req1_op : req0_op;
        a_d     = grant ? req1_a  : req0_a;
        b_d     = grant ? req1_b  : req0_b;
        id_d    = grant;
        state_d = EXEC;
      end
      EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_result_d = alu_result;
        rsp_zero_d   = (alu_result == '0);
        rsp_err_d    = alu_err;
        state_d      = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d  = 1'b0;
        last_grant_d = rsp_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_result;

  int n_vec = 0;
  int n_err = 0;
  bit m_last = 1'b1;

  alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU straight from the op-code table.
  task automatic ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output bit e);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b100: r = ~(a | b);
      3'b010: r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      3'b110: r = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One complete transaction: present, check grant, latency, result, backpressure hold, release.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                        input int stall);
    bit ew, ee;
    int t;
    logic [31:0] er;
    logic [35:0] held;
    @(posedge clk); #1;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready = 1'b0;
    ew = (v0 && v1) ? !m_last : v1;
    if (ew) ref_alu(o1, a1, b1, er, ee);
    else    ref_alu(o0, a0, b0, er, ee);
    @(negedge clk);
    t = 0;
    while (!(req0_ready || req1_ready) && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("grant", {req1_ready, req0_ready}, ew ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    if (ew) req1_valid = 1'b0; else req0_valid = 1'b0;
    @(negedge clk);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_ready", {req1_ready, req0_ready}, 0);
    @(negedge clk);
    chk("latency_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, ew);
    chk("rsp_result", rsp_result, er);
    chk("rsp_zero", rsp_zero, (er == 32'd0));
    chk("rsp_err", rsp_err, ee);
    chk("resp_ready", {req1_ready, req0_ready}, 0);
    held = {1'b1, ew, er, (er == 32'd0), ee};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_hold", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err}, held);
      chk("stall_ready", {req1_ready, req0_ready}, 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    m_last = ew;
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);
  endtask

  // Both requesters valid continuously with a free consumer.
  task automatic tput();
    int acc_cyc[$];
    bit acc_id[$];
    bit e;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1'b1; req1_op = 3'b001; req1_a = $urandom; req1_b = $urandom;
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        acc_cyc.push_back(i);
        acc_id.push_back(req1_ready);
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    chk("tput_count", acc_cyc.size(), 4);
    e = !m_last;
    for (int k = 0; k < acc_cyc.size(); k++) begin
      chk("tput_order", acc_id[k], e);
      if (k > 0) chk("tput_gap", acc_cyc[k] - acc_cyc[k-1], 3);
      e = !e;
    end
    m_last = !e;
    @(negedge clk);
    chk("tput_drain", rsp_valid, 0);
  endtask

  initial begin
    bit v0, v1;
    #2;
    chk("reset_outputs", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err}, 0);
    chk("reset_ready", {req1_ready, req0_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    m_last = 1'b1;

    // NOR of all-zeros and all-ones
    run_op(1, 0, 3'b100, 32'h0, 32'hFFFF_FFFF, 3'b000, 32'h0, 32'h0, 0);
    tput();
    // wrap-around add under a 5-cycle stall
    run_op(0, 1, 3'b000, 32'h0, 32'h0, 3'b010, 32'hFFFF_FFFF, 32'h1, 5);
    run_op(1, 0, 3'b111, 32'hFFFF_FFFF, 32'h1, 3'b000, 32'h0, 32'h0, 0);
    run_op(0, 1, 3'b000, 32'h0, 32'h0, 3'b111, 32'h1, 32'hFFFF_FFFF, 0);
    run_op(1, 1, 3'b110, 32'd5, 32'd7, 3'b110, 32'd5, 32'd7, 1);
    run_op(1, 0, 3'b011, 32'h1234, 32'h5678, 3'b000, 32'h0, 32'h0, 0);
    run_op(1, 0, 3'b001, 32'h1234, 32'h5678, 3'b000, 32'h0, 32'h0, 0);

    // reset during EXEC discards the op
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd3; req0_b = 32'd4;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset_exec_valid", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    m_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_no_rsp", rsp_valid, 0);
    end
    run_op(1, 1, 3'b000, $urandom, $urandom, 3'b001, $urandom, $urandom, 0);

    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      run_op(v0, v1, 3'($urandom), rnd_word(), rnd_word(),
             3'($urandom), rnd_word(), rnd_word(), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
